// File: rtl/wm_sched_pkg.sv
// Shared types and default geometry for the capture -> watermark frame scheduler.
package wm_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE,
      DONE
   } state_t;

   localparam int FRAME_W          = 640;
   localparam int FRAME_H          = 480;
   localparam int DEF_FRAME_PIXELS = FRAME_W * FRAME_H;

   localparam int DEF_ADDR_W = 19;
   localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/wm_fb_arbiter.sv
// Fixed-priority 2:1 frame-buffer write-port mux (pixel over host) with registered outputs.
module wm_fb_arbiter
   import wm_sched_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_ok,
   input  logic [ADDR_W-1:0] pix_addr,
   input  logic [DATA_W-1:0] pix_data,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_gnt,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_din
);

   assign host_gnt = host_req & ~pix_ok;

   // Address/data hold their last value on idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_din  <= '0;
      end else begin
         fb_we <= pix_ok | host_req;
         if (pix_ok) begin
            fb_addr <= pix_addr;
            fb_din  <= pix_data;
         end else if (host_req) begin
            fb_addr <= host_addr;
            fb_din  <= host_data;
         end
      end
   end

endmodule

// File: rtl/wm_frame_scheduler.sv
// Frame-level capture controller and frame-buffer write arbitration.
// Optional watchdog enabled by defining WM_FRAME_TIMEOUT_EN.
module wm_frame_scheduler
   import wm_sched_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int FRAME_PIXELS   = DEF_FRAME_PIXELS,
   parameter int FCNT_W         = 16,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              cmd_start,
   input  logic              cmd_stop,
   input  logic              mode_cont,
   input  logic [DATA_W-1:0] wked_pixel,
   input  logic              wked_pixel_ready,
   input  logic [ADDR_W-1:0] wked_pixel_adrr,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_gnt,
   output logic              cap_enable,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_din,
   output logic              frame_done,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              err_short,
   output logic              err_long,
   output logic              err_timeout,
   output logic              busy
);

   localparam int                CNT_W    = $clog2(FRAME_PIXELS + 2);
   localparam logic [CNT_W-1:0]  PIX_FULL = CNT_W'(FRAME_PIXELS);
   localparam logic [CNT_W-1:0]  PIX_SAT  = CNT_W'(FRAME_PIXELS + 1);
   localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(FRAME_PIXELS);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t           state, state_nxt;
   logic             vsync_d, vs_fall, vs_rise;
   logic             stop_pending, addr_ok, pix_ok, timeout, leave_idle;
   logic [CNT_W-1:0] pix_cnt;

   assign vs_fall    = vsync_d & ~vsync;
   assign vs_rise    = ~vsync_d & vsync;
   assign addr_ok    = wked_pixel_adrr < ADDR_LIM;
   assign pix_ok     = wked_pixel_ready & (state == CAPTURE) & addr_ok;
   assign leave_idle = (state == IDLE) && (state_nxt == ARMED);

`ifdef WM_FRAME_TIMEOUT_EN
   localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_cnt;
   logic            wd_run;

   assign wd_run  = (state == ARMED) || (state == CAPTURE);
   assign timeout = wd_run && (wd_cnt == WD_LAST);

   always_ff @(posedge pclk) begin
      if (rst || !wd_run || (state_nxt != state)) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         err_timeout <= 1'b0;
      end else if (timeout) begin
         err_timeout <= 1'b1;
      end else if (leave_idle) begin
         err_timeout <= 1'b0;
      end
   end
`else
   assign timeout     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_start && !cmd_stop) state_nxt = ARMED;
         ARMED:   if (cmd_stop || timeout) state_nxt = IDLE;
                  else if (vs_fall) state_nxt = CAPTURE;
         CAPTURE: if (timeout) state_nxt = IDLE;
                  else if (vs_rise) state_nxt = DONE;
         DONE:    state_nxt = (stop_pending || !mode_cont) ? IDLE : ARMED;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state        <= IDLE;
         vsync_d      <= 1'b1;
         stop_pending <= 1'b0;
         pix_cnt      <= '0;
         frame_cnt    <= '0;
         err_short    <= 1'b0;
         err_long     <= 1'b0;
         cap_enable   <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         vsync_d    <= vsync;
         cap_enable <= (state_nxt == CAPTURE);
         busy       <= (state_nxt != IDLE);
         frame_done <= (state_nxt == DONE);

         if (state_nxt == IDLE) begin
            stop_pending <= 1'b0;
         end else if ((state == CAPTURE) && cmd_stop) begin
            stop_pending <= 1'b1;
         end

         if ((state == ARMED) && (state_nxt == CAPTURE)) begin
            pix_cnt <= '0;
         end else if (pix_ok && (pix_cnt != PIX_SAT)) begin
            pix_cnt <= pix_cnt + 1'b1;
         end

         if (leave_idle) begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
         end else begin
            if ((pix_ok && (pix_cnt >= PIX_FULL)) ||
                (wked_pixel_ready && (state == CAPTURE) && !addr_ok)) begin
               err_long <= 1'b1;
            end
            if ((state == DONE) && (pix_cnt < PIX_FULL)) begin
               err_short <= 1'b1;
            end
         end

         if (state == DONE) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   wm_fb_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_arb (
      .clk       (pclk),
      .rst       (rst),
      .pix_ok    (pix_ok),
      .pix_addr  (wked_pixel_adrr),
      .pix_data  (wked_pixel),
      .host_req  (host_req),
      .host_addr (host_addr),
      .host_data (host_data),
      .host_gnt  (host_gnt),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_din    (fb_din)
   );

endmodule
